// File: rtl/instr_cache_sa.sv
// instr_cache_sa: N-way set-associative instruction cache with a same-cycle
// hit path and a two-state refill FSM (IDLE/REFILL). Victim is the lowest
// invalid way, otherwise a per-set round-robin pointer. A full invalidate
// arriving during a refill marks the returning block as stale.
// Optional feature: define INSTR_CACHE_PERF_CNT_EN to add o_hit_cnt/o_miss_cnt.
// Assumes WORD_SIZE >= 16 and BLOCK_WIDTH > WORD_SIZE so all address fields exist.
module instr_cache_sa #(
    parameter int WAYS        = 2,
    parameter int SETS        = 4,
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WIDTH = 512,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   i_req,
    input  logic [ADDR_WIDTH-1:0]  i_instr_addr,
    input  logic                   i_invalidate_instr,
    output logic [WORD_SIZE-1:0]   o_instr,
    output logic                   o_hit,
    output logic                   o_instr_addr_ma,
    output logic                   o_stall,
    output logic                   o_mem_req,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_valid,
    input  logic [BLOCK_WIDTH-1:0] i_mem_block
`ifdef INSTR_CACHE_PERF_CNT_EN
    ,
    output logic [31:0]            o_hit_cnt,
    output logic [31:0]            o_miss_cnt
`endif
);
    localparam int OFS   = $clog2(WORD_SIZE / 8);
    localparam int WOFS  = $clog2(BLOCK_WIDTH / WORD_SIZE);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = ADDR_WIDTH - IDX - WOFS - OFS;
    localparam int WPB   = BLOCK_WIDTH / WORD_SIZE;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [WAY_W-1:0]        victim_reg, victim_next;
    logic                    drop_reg;
    logic                    all_valid;

    // Storage: tag/data are plain arrays (never reset); valid and rr are reset.
    logic [TAG-1:0]          tag_mem  [WAYS][SETS];
    logic [BLOCK_WIDTH-1:0]  data_mem [WAYS][SETS];
    logic [WAYS-1:0]         valid_reg [SETS];
    logic [WAY_W-1:0]        rr_reg    [SETS];

    // Request address split
    logic [TAG-1:0]  req_tag;
    logic [IDX-1:0]  req_idx;
    logic [WOFS-1:0] req_wofs;
    assign req_tag  = i_instr_addr[ADDR_WIDTH-1 -: TAG];
    assign req_idx  = i_instr_addr[OFS+WOFS +: IDX];
    assign req_wofs = i_instr_addr[OFS +: WOFS];

    // Refill target comes from the latched block address
    logic [TAG-1:0] fill_tag;
    logic [IDX-1:0] fill_idx;
    assign fill_tag = mem_addr_reg[ADDR_WIDTH-1 -: TAG];
    assign fill_idx = mem_addr_reg[OFS+WOFS +: IDX];

    logic [WAYS-1:0]      hit_vec;
    logic [WORD_SIZE-1:0] way_word [WAYS];

    // Per-way tag compare and word select
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            logic [WPB-1:0][WORD_SIZE-1:0] line;
            assign line        = data_mem[gi][req_idx];
            assign hit_vec[gi] = valid_reg[req_idx][gi] && (tag_mem[gi][req_idx] == req_tag);
            assign way_word[gi] = hit_vec[gi] ? line[req_wofs] : '0;
        end
    endgenerate

    // OR-merge the hitting way's word (at most one way hits)
    always_comb begin
        o_instr = '0;
        for (int w = 0; w < WAYS; w++) o_instr = o_instr | way_word[w];
    end

    assign o_hit           = |hit_vec;
    assign o_instr_addr_ma = |i_instr_addr[OFS-1:0];
    assign o_mem_addr      = mem_addr_reg;

    logic miss_start, fill_we;
    assign miss_start = (state_reg == IDLE) && i_req && !o_hit && !o_instr_addr_ma;
    assign fill_we    = (state_reg == REFILL) && i_mem_valid;

    // Victim: lowest invalid way, otherwise the set's round-robin pointer
    always_comb begin
        victim_next = rr_reg[req_idx];
        all_valid   = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[req_idx][w]) begin
                victim_next = WAY_W'(w);
                all_valid   = 1'b0;
            end
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_next = state_reg;
        o_mem_req  = 1'b0;
        o_stall    = (state_reg != IDLE) || (i_req && !o_hit && !o_instr_addr_ma);
        case (state_reg)
            IDLE:    if (miss_start) state_next = REFILL;
            REFILL: begin
                o_mem_req = 1'b1;
                if (i_mem_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, latched refill address/victim, stale-block flag
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg    <= IDLE;
            mem_addr_reg <= '0;
            victim_reg   <= '0;
            drop_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (miss_start) begin
                mem_addr_reg <= {i_instr_addr[ADDR_WIDTH-1:OFS+WOFS], {(OFS+WOFS){1'b0}}};
                victim_reg   <= victim_next;
            end
            if (state_reg == REFILL)
                drop_reg <= i_mem_valid ? 1'b0 : (drop_reg || i_invalidate_instr);
            else
                drop_reg <= 1'b0;
        end
    end

    // Valid bits and round-robin pointers; invalidate overrides any update
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                rr_reg[s]    <= '0;
            end
        end else if (i_invalidate_instr) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                rr_reg[s]    <= '0;
            end
        end else begin
            if (fill_we && !drop_reg) valid_reg[fill_idx][victim_reg] <= 1'b1;
            if (miss_start && all_valid)
                rr_reg[req_idx] <= (WAYS > 1) ? rr_reg[req_idx] + 1'b1 : '0;
        end
    end

    // Tag/data write on refill (a stale block may land here but stays invalid)
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[victim_reg][fill_idx] <= i_mem_block;
            tag_mem[victim_reg][fill_idx]  <= fill_tag;
        end
    end

`ifdef INSTR_CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;
    // Hit counter per hitting IDLE request cycle, miss counter per refill start
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (i_req && o_hit && (state_reg == IDLE)) hit_cnt_reg <= hit_cnt_reg + 32'd1;
            if (miss_start) miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end
    assign o_hit_cnt  = hit_cnt_reg;
    assign o_miss_cnt = miss_cnt_reg;
`endif
endmodule

// File: tb/tb_instr_cache_sa.sv
// Scoreboard bench for instr_cache_sa: fetch and refill-address expectations
// are queued by the stimulus and popped by an independent monitor.
module tb_instr_cache_sa;
    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic         i_req = 1'b0;
    logic [31:0]  i_instr_addr = '0;
    logic         i_invalidate_instr = 1'b0;
    logic [31:0]  o_instr;
    logic         o_hit, o_instr_addr_ma, o_stall, o_mem_req;
    logic [31:0]  o_mem_addr;
    logic         i_mem_valid = 1'b0;
    logic [511:0] i_mem_block = '0;
`ifdef INSTR_CACHE_PERF_CNT_EN
    logic [31:0]  o_hit_cnt, o_miss_cnt;
`endif

    instr_cache_sa dut (
        .clk(clk), .arst(arst), .i_req(i_req), .i_instr_addr(i_instr_addr),
        .i_invalidate_instr(i_invalidate_instr), .o_instr(o_instr), .o_hit(o_hit),
        .o_instr_addr_ma(o_instr_addr_ma), .o_stall(o_stall), .o_mem_req(o_mem_req),
        .o_mem_addr(o_mem_addr), .i_mem_valid(i_mem_valid), .i_mem_block(i_mem_block)
`ifdef INSTR_CACHE_PERF_CNT_EN
        , .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        hit;
        logic [31:0] instr;
        logic        ma;
    } fetch_exp_t;

    fetch_exp_t  fetch_q [$];
    logic [31:0] mem_q [$];
    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    bit mem_auto = 1'b1;
    int mem_lat = 3;
    logic mem_req_d = 1'b0;
    fetch_exp_t mon_e;
    logic [31:0] mon_a;

    // Memory image: each word holds its own address + 0x1000_0000,
    // except word 1 of block 0x40 which is 0xDEADBEEF.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (a[31:6] == 26'd1 && a[5:2] == 4'd1) return 32'hDEADBEEF;
        return {a[31:2], 2'b00} + 32'h1000_0000;
    endfunction

    function automatic logic [511:0] make_block(input logic [31:0] base);
        logic [511:0] b;
        b = '0;
        for (int w = 0; w < 16; w++) b[w*32 +: 32] = exp_word({base[31:6], 4'(w), 2'b00});
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end else begin
            $display("ok   %s value=%h", nm, act);
        end
    endtask

    // Monitor: pops a fetch expectation whenever a request is accepted,
    // and a refill-address expectation on each rising o_mem_req.
    always @(negedge clk) begin
        if (!arst) begin
            if (i_req && !o_stall) begin
                if (fetch_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fetch addr=%h actual=none required=none", i_instr_addr);
                end else begin
                    mon_e = fetch_q.pop_front();
                    chk($sformatf("fetch_addr %h", mon_e.addr), 64'(i_instr_addr), 64'(mon_e.addr));
                    chk($sformatf("hit %h", mon_e.addr), 64'(o_hit), 64'(mon_e.hit));
                    chk($sformatf("instr %h", mon_e.addr), 64'(o_instr), 64'(mon_e.instr));
                    chk($sformatf("ma %h", mon_e.addr), 64'(o_instr_addr_ma), 64'(mon_e.ma));
                end
            end
            if (o_mem_req && !mem_req_d) begin
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req actual=%h required=none", o_mem_addr);
                end else begin
                    mon_a = mem_q.pop_front();
                    chk("mem_addr", 64'(o_mem_addr), 64'(mon_a));
                end
            end
        end
        mem_req_d = o_mem_req;
    end

    // Auto memory: answers a held request after mem_lat cycles
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mem_auto && !arst && o_mem_req && !i_mem_valid) begin
                repeat (mem_lat) begin @(posedge clk); #1; end
                i_mem_valid = 1'b1;
                i_mem_block = make_block(o_mem_addr);
                @(posedge clk); #1;
                i_mem_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // One fetch transaction: queue expectations, hold address until accepted
    task automatic fetch(input logic [31:0] a, input bit miss, input bit hit, input bit ma);
        fetch_exp_t e;
        int n;
        e.addr = a; e.hit = hit; e.instr = hit ? exp_word(a) : 32'h0; e.ma = ma;
        fetch_q.push_back(e);
        if (miss) mem_q.push_back({a[31:6], 6'b0});
        cyc();
        i_req = 1'b1; i_instr_addr = a;
        @(negedge clk);
        chk($sformatf("first_stall %h", a), 64'(o_stall), 64'(miss));
        n = 0;
        while (o_stall && n < 200) begin @(negedge clk); n++; end
        if (o_stall) begin
            checks++; errors++;
            $display("FAIL fetch_timeout %h actual=stalled required=accepted", a);
        end
        cyc();
        i_req = 1'b0;
        if (miss) exp_misses++;
        if (hit) exp_hits++;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_hit", 64'(o_hit), 64'h0);
        chk("rst_instr", 64'(o_instr), 64'h0);
        chk("rst_stall", 64'(o_stall), 64'h0);
        chk("rst_mem_req", 64'(o_mem_req), 64'h0);
        chk("rst_mem_addr", 64'(o_mem_addr), 64'h0);
`ifdef INSTR_CACHE_PERF_CNT_EN
        chk("rst_hit_cnt", 64'(o_hit_cnt), 64'h0);
        chk("rst_miss_cnt", 64'(o_miss_cnt), 64'h0);
`endif
        cyc(); arst = 1'b0;
        cyc();

        // Misaligned fetch on a cold cache: no stall, no refill
        fetch(32'h0000_0042, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ma_no_mem_req", 64'(o_mem_req), 64'h0);

        // Cold miss on 0x40 then hit on 0x44
        fetch(32'h0000_0040, 1'b1, 1'b1, 1'b0);
        fetch(32'h0000_0044, 1'b0, 1'b1, 1'b0);

        // Set 0 replacement sequence
        fetch(32'h0000_0000, 1'b1, 1'b1, 1'b0);
        fetch(32'h0000_0108, 1'b1, 1'b1, 1'b0);
        fetch(32'h0000_0000, 1'b0, 1'b1, 1'b0);
        fetch(32'h0000_0108, 1'b0, 1'b1, 1'b0);
        fetch(32'h0000_0200, 1'b1, 1'b1, 1'b0);
        fetch(32'h0000_0300, 1'b1, 1'b1, 1'b0);
        fetch(32'h0000_0000, 1'b1, 1'b1, 1'b0);
        fetch(32'h0000_0300, 1'b0, 1'b1, 1'b0);
        fetch(32'h0000_0200, 1'b1, 1'b1, 1'b0);
`ifdef INSTR_CACHE_PERF_CNT_EN
        @(negedge clk);
        chk("hit_cnt", 64'(o_hit_cnt), 64'(exp_hits));
        chk("miss_cnt", 64'(o_miss_cnt), 64'(exp_misses));
`endif

        // Invalidate during refill: block dropped, second refill issued
        mem_auto = 1'b0;
        fetch_q.push_back('{addr: 32'h540, hit: 1'b1, instr: exp_word(32'h540), ma: 1'b0});
        mem_q.push_back(32'h540);
        mem_q.push_back(32'h540);
        cyc(); i_req = 1'b1; i_instr_addr = 32'h540;
        cyc();
        cyc(); i_invalidate_instr = 1'b1;
        cyc(); i_invalidate_instr = 1'b0; i_mem_valid = 1'b1; i_mem_block = make_block(32'h540);
        cyc(); i_mem_valid = 1'b0; mem_auto = 1'b1;
        @(negedge clk);
        chk("drop_hit", 64'(o_hit), 64'h0);
        chk("drop_stall", 64'(o_stall), 64'h1);
        begin
            int n = 0;
            while (o_stall && n < 200) begin @(negedge clk); n++; end
            if (o_stall) begin
                checks++; errors++;
                $display("FAIL drop_refill_timeout actual=stalled required=accepted");
            end
        end
        cyc(); i_req = 1'b0;
        // 0x40 was invalidated: must miss again
        fetch(32'h0000_0044, 1'b1, 1'b1, 1'b0);

        // Async reset mid-refill, late block ignored
        mem_auto = 1'b0;
        mem_q.push_back(32'h7C0);
        cyc(); i_req = 1'b1; i_instr_addr = 32'h7C0;
        cyc();
        cyc();
        arst = 1'b1; i_req = 1'b0;
        #1;
        chk("arst_mem_req", 64'(o_mem_req), 64'h0);
        cyc(); arst = 1'b0;
        cyc(); i_mem_valid = 1'b1; i_mem_block = make_block(32'h7C0);
        cyc(); i_mem_valid = 1'b0;
        @(negedge clk);
        chk("late_mem_req", 64'(o_mem_req), 64'h0);
        chk("late_hit", 64'(o_hit), 64'h0);
        chk("late_stall", 64'(o_stall), 64'h0);
`ifdef INSTR_CACHE_PERF_CNT_EN
        chk("arst_hit_cnt", 64'(o_hit_cnt), 64'h0);
        chk("arst_miss_cnt", 64'(o_miss_cnt), 64'h0);
`endif
        mem_auto = 1'b1;
        repeat (2) @(negedge clk);
        chk("fetch_q_empty", 64'(fetch_q.size()), 64'h0);
        chk("mem_q_empty", 64'(mem_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
